core_dispatch_scheduler: RTL

- Schedules point validation across CORE_NUMBER validator cores: primes every core with a point index, round-robin arbitrates finished cores, reloads them with the next index, and queues outlier indices in an internal FIFO drained over a valid/ready stream.
- Sits between the cache/feeder datapath and the validator_core array, replacing per-cycle loop scanning with one grant per cycle and explicit backpressure.

---
 rtl/core_dispatch_scheduler_pkg.sv | 30 +++
 rtl/core_dispatch_scheduler_if.sv | 28 ++
 rtl/core_dispatch_scheduler_rr_arbiter.sv | 37 +++
 rtl/core_dispatch_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/core_dispatch_scheduler_pkg.sv
// Shared definitions for the dispatch scheduler: state encoding, default sizes
// and the pointer-width helper.
package core_dispatch_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  localparam int DEF_N           = 16;
  localparam int DEF_CORE_NUMBER = 16;
  localparam int DEF_FIFO_DEPTH  = 32;

  // Bits needed to index 'value' entries, never less than one.
  function automatic int clog2_min1(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/core_dispatch_scheduler_if.sv
// Bundle of the scheduler's run-control, core-array and outlier-stream signals.
interface core_dispatch_scheduler_if #(
  parameter int N           = 16,
  parameter int CORE_NUMBER = 16
);
  logic                   start;
  logic [2*N-1:0]         point_cloud_size;
  logic [CORE_NUMBER-1:0] core_finish;
  logic [CORE_NUMBER-1:0] core_outlier;
  logic [CORE_NUMBER-1:0] core_load;
  logic [2*N-1:0]         load_index;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*N-1:0]         out_index;
  logic                   busy;
  logic                   done;
  logic [2*N-1:0]         stall_cycles;

  modport master (
    input  start, point_cloud_size, core_finish, core_outlier, out_ready,
    output core_load, load_index, out_valid, out_index, busy, done, stall_cycles
  );

  modport slave (
    output start, point_cloud_size, core_finish, core_outlier, out_ready,
    input  core_load, load_index, out_valid, out_index, busy, done, stall_cycles
  );
endinterface

// File: rtl/core_dispatch_scheduler_rr_arbiter.sv
// Round-robin picker: first requesting core at or after the pointer, with wrap-around.
module core_dispatch_scheduler_rr_arbiter #(
  parameter int CORE_NUMBER = 16,
  parameter int PW          = 4
) (
  input  logic [CORE_NUMBER-1:0] req,
  input  logic [PW-1:0]          ptr,
  output logic [CORE_NUMBER-1:0] grant,
  output logic [PW-1:0]          grant_idx,
  output logic                   grant_valid
);

  // Scan from the pointer, keeping only the first hit.
  always_comb begin
    int cand;
    cand        = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < CORE_NUMBER; i++) begin
      cand = int'(ptr) + i;
      if (cand >= CORE_NUMBER) begin
        cand = cand - CORE_NUMBER;
      end else begin
        cand = cand;
      end
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(cand);
        grant[cand] = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/core_dispatch_scheduler.sv
// Dispatch scheduler: primes validator cores, reloads finished ones round-robin and
// queues outlier indices. Define SCHED_STATS_EN to enable the stall_cycles counter.
module core_dispatch_scheduler
  import core_dispatch_scheduler_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int CORE_NUMBER = DEF_CORE_NUMBER,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input logic clock,
  input logic reset,
  core_dispatch_scheduler_if.master bus
);

  localparam int W  = 2 * N;
  localparam int PW = clog2_min1(CORE_NUMBER);
  localparam int AW = clog2_min1(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [W-1:0]           CORES_W  = W'(CORE_NUMBER);
  localparam logic [CW-1:0]          DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CORE_NUMBER-1:0] ONE_HOT0 = CORE_NUMBER'(1);

  sched_state_t           state;
  logic [W-1:0]           size_r;
  logic [W-1:0]           prime_k;
  logic [W-1:0]           next_index;
  logic [W-1:0]           load_index_r;
  logic [CORE_NUMBER-1:0] slot_busy;
  logic [CORE_NUMBER-1:0] core_load_r;
  logic [W-1:0]           slot_index [CORE_NUMBER];
  logic [PW-1:0]          rr_ptr;
  logic                   busy_r;
  logic                   done_r;

  logic [W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;

  logic                   out_valid_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   fifo_block_s;
  logic [W-1:0]           prime_len_s;
  logic [CORE_NUMBER-1:0] req_s;
  logic [CORE_NUMBER-1:0] grant_s;
  logic [PW-1:0]          grant_idx_s;
  logic                   grant_valid_s;

  assign out_valid_s  = (fifo_count != '0);
  assign pop_s        = out_valid_s & bus.out_ready;
  // A pop in the same cycle frees the slot a push needs, so full alone does not block.
  assign fifo_block_s = (fifo_count == DEPTH_C) & ~pop_s;
  assign prime_len_s  = (size_r < CORES_W) ? size_r : CORES_W;
  assign req_s = (state == RUN)
               ? (bus.core_finish & slot_busy & ~core_load_r
                  & ~(bus.core_outlier & {CORE_NUMBER{fifo_block_s}}))
               : '0;
  assign push_s = grant_valid_s & bus.core_outlier[grant_idx_s];

  core_dispatch_scheduler_rr_arbiter #(
    .CORE_NUMBER (CORE_NUMBER),
    .PW          (PW)
  ) u_arb (
    .req         (req_s),
    .ptr         (rr_ptr),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Run-control FSM with registered core_load/load_index/busy/done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      size_r       <= '0;
      prime_k      <= '0;
      next_index   <= '0;
      load_index_r <= '0;
      slot_busy    <= '0;
      core_load_r  <= '0;
      rr_ptr       <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      for (int i = 0; i < CORE_NUMBER; i++) begin
        slot_index[i] <= '0;
      end
    end else begin
      core_load_r <= '0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            size_r     <= bus.point_cloud_size;
            prime_k    <= '0;
            next_index <= '0;
            rr_ptr     <= '0;
            slot_busy  <= '0;
            if (bus.point_cloud_size == '0) begin
              state  <= DONE;
              done_r <= 1'b1;
              busy_r <= 1'b0;
            end else begin
              state  <= PRIME;
              done_r <= 1'b0;
              busy_r <= 1'b1;
            end
          end
        end
        PRIME: begin
          core_load_r                  <= ONE_HOT0 << prime_k[PW-1:0];
          load_index_r                 <= prime_k;
          slot_busy[prime_k[PW-1:0]]   <= 1'b1;
          slot_index[prime_k[PW-1:0]]  <= prime_k;
          prime_k                      <= prime_k + W'(1);
          if ((prime_k + W'(1)) == prime_len_s) begin
            state      <= RUN;
            next_index <= prime_len_s;
          end
        end
        RUN: begin
          if (grant_valid_s) begin
            rr_ptr <= (grant_idx_s == PW'(CORE_NUMBER - 1)) ? '0 : grant_idx_s + PW'(1);
            if (next_index < size_r) begin
              core_load_r             <= grant_s;
              load_index_r            <= next_index;
              slot_index[grant_idx_s] <= next_index;
              next_index              <= next_index + W'(1);
            end else begin
              slot_busy[grant_idx_s] <= 1'b0;
            end
          end
          if (slot_busy == '0) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_count == '0) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  // Outlier FIFO pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_s) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_s) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_count <= fifo_count + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    end
  end

  // Outlier storage; entries are only observed behind out_valid, so no reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_mem[wr_ptr] <= slot_index[grant_idx_s];
    end
  end

  assign bus.core_load  = core_load_r;
  assign bus.load_index = load_index_r;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_index  = out_valid_s ? fifo_mem[rd_ptr] : '0;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

`ifdef SCHED_STATS_EN
  logic [W-1:0]           stall_r;
  logic [CORE_NUMBER-1:0] blocked_s;

  assign blocked_s = bus.core_finish & bus.core_outlier & slot_busy & ~core_load_r;

  // Saturating count of RUN cycles in which a ready outlier waited on a full FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_r <= '0;
    end else if (((state == IDLE) || (state == DONE)) && bus.start) begin
      stall_r <= '0;
    end else if ((state == RUN) && fifo_block_s && (|blocked_s) && (stall_r != '1)) begin
      stall_r <= stall_r + W'(1);
    end
  end

  assign bus.stall_cycles = stall_r;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule
